// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped prescaled 32-bit timer with compare, sticky
// match flag and level irq. Ports: clk, rst_n, a, write_byte_enable, we,
// wd in; rd, hit, irq out. rd/hit are combinational from a.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [3:0]  write_byte_enable,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        irq
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_COUNT  = 3'd2;
  localparam logic [2:0] OFF_CMP    = 3'd3;
  localparam logic [2:0] OFF_PRE    = 3'd4;

  logic        en;
  logic        autoreload;
  logic        irq_en;
  logic        pending;
  logic [31:0] count;
  logic [31:0] compare;
  logic [15:0] prescale;
  logic [15:0] pcnt;

  logic [2:0]  sel;
  logic [3:0]  be;
  logic        wr;
  logic        any_be;
  logic        tick;
  logic        match;
  logic        ctl_wr;
  logic        cnt_wr;
  logic        cmp_wr;
  logic        pre_wr;
  logic        sts_clr;
  logic        unused_addr;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  lanes
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  assign unused_addr = ^a[1:0];

  assign hit    = (a[31:5] == BASE_ADDR[31:5]);
  assign sel    = a[4:2];
  assign be     = write_byte_enable;
  assign any_be = |be;
  assign wr     = we & hit;

  assign ctl_wr  = wr && (sel == OFF_CTRL);
  assign cnt_wr  = wr && (sel == OFF_COUNT) && any_be;
  assign cmp_wr  = wr && (sel == OFF_CMP);
  assign pre_wr  = wr && (sel == OFF_PRE) && any_be;
  assign sts_clr = wr && (sel == OFF_STATUS)
                   && be[0] && wd[0];

  // tick and match decisions use pre-edge register values
  assign tick  = en && (pcnt == prescale);
  assign match = (count == compare);

  assign irq = pending & irq_en;

  always_comb begin
    rd = '0;
    if (hit) begin
      unique case (sel)
        OFF_CTRL:   rd = {29'd0, irq_en, autoreload, en};
        OFF_STATUS: rd = {31'd0, pending};
        OFF_COUNT:  rd = count;
        OFF_CMP:    rd = compare;
        OFF_PRE:    rd = {16'd0, prescale};
        default:    rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      irq_en     <= 1'b0;
    end else if (ctl_wr && be[0]) begin
      en         <= wd[0];
      autoreload <= wd[1];
      irq_en     <= wd[2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare <= '0;
    end else if (cmp_wr) begin
      compare <= merge(compare, wd, be);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (pre_wr) begin
      if (be[0]) prescale[7:0]  <= wd[7:0];
      if (be[1]) prescale[15:8] <= wd[15:8];
    end
  end

  // a prescale write restarts the divider so the new period is exact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (pre_wr || tick) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= pcnt + 16'd1;
    end
  end

  // a CPU write to COUNT overrides the tick and suppresses its match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cnt_wr) begin
      count <= merge(count, wd, be);
    end else if (tick) begin
      if (match && autoreload) count <= '0;
      else                     count <= count + 32'd1;
    end
  end

  // set beats a same-edge write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (tick && !cnt_wr && match) begin
      pending <= 1'b1;
    end else if (sts_clr) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus randomized bus traffic, all
// checked against a behavioural model of the timer held in the bench.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STS  = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_PRE  = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        hit;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic        m_en, m_ar, m_ie, m_pend;
  logic [31:0] m_cnt, m_cmp;
  logic [15:0] m_pre;
  int          m_pcnt;

  mmio_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a(a),
    .write_byte_enable(be),
    .we(we),
    .wd(wd),
    .rd(rd),
    .hit(hit),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lanes(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  m
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic in_win(input logic [31:0] x);
    return x[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] x);
    if (!in_win(x)) return 32'd0;
    case (x[4:2])
      3'd0: return {29'd0, m_ie, m_ar, m_en};
      3'd1: return {31'd0, m_pend};
      3'd2: return m_cnt;
      3'd3: return m_cmp;
      3'd4: return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0;
    m_cnt = 0; m_cmp = 0; m_pre = 0; m_pcnt = 0;
  endtask

  // one clock edge of the timer, from pre-edge state and bus inputs
  task automatic m_edge();
    logic        w;
    logic [2:0]  o;
    logic        ticked;
    logic        set;
    logic        cnt_w;
    logic [31:0] n_cnt;
    int          n_pcnt;
    w = we && in_win(a);
    o = a[4:2];
    ticked = m_en && (m_pcnt == int'(m_pre));
    cnt_w = w && o == 3'd2 && be != 0;
    set = 0;
    n_cnt = m_cnt;
    n_pcnt = m_pcnt;
    if (m_en) n_pcnt = ticked ? 0 : m_pcnt + 1;
    if (cnt_w) begin
      n_cnt = lanes(m_cnt, wd, be);
    end else if (ticked) begin
      if (m_cnt == m_cmp) begin
        set = 1;
        n_cnt = m_ar ? 32'd0 : m_cnt + 1;
      end else begin
        n_cnt = m_cnt + 1;
      end
    end
    if (w && o == 3'd4 && be != 0) n_pcnt = 0;
    if (w && o == 3'd0 && be[0]) begin
      m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2];
    end
    if (w && o == 3'd3) m_cmp = lanes(m_cmp, wd, be);
    if (w && o == 3'd4) begin
      if (be[0]) m_pre[7:0] = wd[7:0];
      if (be[1]) m_pre[15:8] = wd[15:8];
    end
    if (set) m_pend = 1;
    else if (w && o == 3'd1 && be[0] && wd[0]) m_pend = 0;
    m_cnt = n_cnt;
    m_pcnt = n_pcnt;
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic wr(
    input logic [31:0] ad,
    input logic [31:0] d,
    input logic [3:0]  m
  );
    a = ad; wd = d; be = m; we = 1;
    step();
    we = 0; be = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic look(input logic [31:0] ad);
    a = ad; we = 0; be = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      look(BASE + 32'(i * 4));
      checks++;
      if (rd !== 32'd0 || hit !== 1'b1) begin
        errors++;
        $display("FAIL reset_rd off=%0d rd=%h hit=%b want 0/1",
                 i * 4, rd, hit);
      end
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq got=%b want 0", irq);
    end
    look(32'h0000_0100);
    checks++;
    if (hit !== 1'b0 || rd !== 32'd0) begin
      errors++;
      $display("FAIL reset_miss hit=%b rd=%h want 0/0", hit, rd);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_lanes();
    wr(A_CMP, 32'hAABBCCDD, 4'hF);
    look(A_CMP);
    checks++;
    if (rd !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL cmp_full got=%h want aabbccdd", rd);
    end
    wr(A_CMP, 32'h11223344, 4'b0101);
    look(A_CMP);
    checks++;
    if (rd !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL cmp_lanes got=%h want aa22cc44", rd);
    end
    wr(A_CMP, 32'h55667788, 4'b0000);
    look(A_CMP + 32'd3);
    checks++;
    if (rd !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL cmp_be0 got=%h want aa22cc44", rd);
    end
    wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    look(BASE + 32'h14);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL reserved got=%h want 0", rd);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] want [3];
    int          gap  [3];
    want[0] = 32'd0; want[1] = 32'd1; want[2] = 32'd5;
    gap[0] = 3; gap[1] = 1; gap[2] = 16;
    wr(A_PRE, 32'hFFFF_0003, 4'hF);
    wr(A_CNT, 32'd0, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      idle(gap[k]);
      look(A_CNT);
      checks++;
      if (rd !== want[k] || rd !== m_cnt) begin
        errors++;
        $display("FAIL pre_cnt%0d got=%h want %h", k, rd, want[k]);
      end
    end
    look(A_PRE);
    checks++;
    if (rd !== 32'd3) begin
      errors++;
      $display("FAIL pre_hi got=%h want 3", rd);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    idle(10);
    look(A_CNT);
    checks++;
    if (rd !== 32'd5) begin
      errors++;
      $display("FAIL frozen got=%h want 5", rd);
    end
  endtask

  task automatic test_match();
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    wr(A_CNT, 32'd3, 4'hF);
    wr(A_STS, 32'd1, 4'hF);
    wr(A_CTRL, 32'd7, 4'hF);
    idle(2);
    look(A_CNT);
    checks++;
    if (rd !== 32'd5 || irq !== 1'b0) begin
      errors++;
      $display("FAIL pre_match cnt=%h irq=%b want 5/0", rd, irq);
    end
    idle(1);
    look(A_CNT);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL autoreload cnt=%h irq=%b want 0/1", rd, irq);
    end
    look(A_STS);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL pend_set got=%h want 1", rd);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_STS, 32'd1, 4'hF);
    wr(A_CNT, 32'd4, 4'hF);
    wr(A_CTRL, 32'd5, 4'hF);
    idle(2);
    look(A_CNT);
    checks++;
    if (rd !== 32'd6 || irq !== 1'b1) begin
      errors++;
      $display("FAIL no_reload cnt=%h irq=%b want 6/1", rd, irq);
    end
  endtask

  task automatic test_w1c_race();
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_STS, 32'd1, 4'hF);
    wr(A_CNT, 32'd4, 4'hF);
    wr(A_CTRL, 32'd5, 4'hF);
    idle(1);
    wr(A_STS, 32'd1, 4'h1);
    look(A_STS);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL w1c_race got=%h want 1", rd);
    end
    wr(A_STS, 32'hFFFF_FFFE, 4'hF);
    look(A_STS);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL w0_noop got=%h want 1", rd);
    end
    wr(A_STS, 32'd1, 4'b1110);
    look(A_STS);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL w1c_lane got=%h want 1", rd);
    end
    wr(A_STS, 32'd1, 4'h1);
    look(A_STS);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clr st=%h irq=%b want 0/0", rd, irq);
    end
  endtask

  task automatic test_wrap_write_wins();
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_STS, 32'd1, 4'hF);
    wr(A_CMP, 32'h10, 4'hF);
    wr(A_PRE, 32'd0, 4'hF);
    wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    idle(1);
    look(A_CNT);
    checks++;
    if (rd !== 32'd0 || m_pend !== 1'b0) begin
      errors++;
      $display("FAIL wrap cnt=%h want 0", rd);
    end
    look(A_STS);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL wrap_pend got=%h want 0", rd);
    end
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_PRE, 32'd2, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    idle(2);
    wr(A_CNT, 32'h100, 4'hF);
    look(A_CNT);
    checks++;
    if (rd !== 32'h100) begin
      errors++;
      $display("FAIL write_wins got=%h want 100", rd);
    end
    idle(2);
    look(A_CNT);
    checks++;
    if (rd !== 32'h100) begin
      errors++;
      $display("FAIL ww_hold got=%h want 100", rd);
    end
    idle(1);
    look(A_CNT);
    checks++;
    if (rd !== 32'h101) begin
      errors++;
      $display("FAIL ww_next got=%h want 101", rd);
    end
  endtask

  task automatic test_reset_mid();
    wr(A_CMP, 32'h33, 4'hF);
    wr(A_CTRL, 32'd7, 4'hF);
    idle(5);
    rst_n = 0;
    m_reset();
    look(A_CNT);
    checks++;
    if (rd !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset cnt=%h irq=%b want 0/0", rd, irq);
    end
    look(A_CMP);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_cmp got=%h want 0", rd);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int          op;
    int          off;
    logic [31:0] ad;
    logic [31:0] d;
    int          bad;
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      op  = int'($urandom_range(0, 9));
      off = int'($urandom_range(0, 7));
      ad  = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        ad = 32'h0000_0100 + 32'(off * 4);
      case (off)
        2, 3:    d = 32'($urandom_range(0, 12));
        4:       d = 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      if (off == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      a = ad;
      wd = d;
      we = (op < 4);
      be = we ? 4'($urandom) : 4'd0;
      #1;
      checks++;
      if (rd !== m_rd(a) || hit !== in_win(a)
          || irq !== (m_pend & m_ie)) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL rand n=%0d a=%h rd=%h/%h hit=%b irq=%b/%b",
                   n, a, rd, m_rd(a), hit, irq, m_pend & m_ie);
      end
      step();
      we = 0;
      be = 0;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_byte_lanes();
    test_prescale();
    test_match();
    test_w1c_race();
    test_wrap_write_wins();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
